// File: rtl/pbs_pkg.sv
// Shared definitions for the pulse burst scheduler: FSM states and LFSR constants.
package pbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/pbs_lfsr.sv
// Right-shifting Galois LFSR that supplies gap jitter; reset seeds it to LFSR_SEED.
module pbs_lfsr
  import pbs_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  // An explicit load wins over a step requested in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= W'(LFSR_SEED);
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= (q >> 1) ^ (q[0] ? W'(LFSR_TAPS) : '0);
    end
  end

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Generates bursts of pulses with programmable width and LFSR-jittered gaps.
// Defining PBS_SEED_LOAD_EN adds the seed/seed_load ports for reseeding the LFSR.
module pulse_burst_scheduler
  import pbs_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int LFSR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]  pulse_width,
  input  logic [CNT_W-1:0]  gap_min,
  input  logic [CNT_W-1:0]  gap_mask,
  output logic              pulse,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pulse_idx,
  output logic [LFSR_W-1:0] lfsr_q
`ifdef PBS_SEED_LOAD_EN
  ,
  input  logic [LFSR_W-1:0] seed,
  input  logic              seed_load
`endif
);

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] gap_min_q;
  logic [CNT_W-1:0] mask_q;
  logic [CNT_W:0]   cnt;
  logic [CNT_W:0]   gap_cnt;
  logic             last_high;
  logic             lfsr_step;
  logic             lfsr_load;
  logic [LFSR_W-1:0] lfsr_load_val;

  // The extra counter bit keeps gap_min plus the full jitter from wrapping.
  assign gap_cnt   = {1'b0, gap_min_q} + {1'b0, lfsr_q[CNT_W-1:0] & mask_q};
  assign last_high = (state == HIGH) && (cnt == '0);
  assign lfsr_step = ena && !abort && last_high && (pulse_idx != len_q);

`ifdef PBS_SEED_LOAD_EN
  assign lfsr_load     = ena && seed_load;
  assign lfsr_load_val = (seed == '0) ? LFSR_W'(1) : seed;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = '0;
`endif

  pbs_lfsr #(
    .W(LFSR_W)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q)
  );

  // Every counter counts down to zero, so a loaded value N spans N+1 cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
      cnt       <= '0;
      len_q     <= '0;
      width_q   <= '0;
      gap_min_q <= '0;
      mask_q    <= '0;
    end else if (ena) begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        pulse     <= 1'b0;
        busy      <= 1'b0;
        pulse_idx <= '0;
        cnt       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len_q     <= burst_len;
              width_q   <= pulse_width;
              gap_min_q <= gap_min;
              mask_q    <= gap_mask;
              if (burst_len != '0) begin
                state     <= HIGH;
                pulse     <= 1'b1;
                busy      <= 1'b1;
                pulse_idx <= CNT_W'(1);
                cnt       <= {1'b0, pulse_width};
              end else begin
                state     <= DONE;
                done      <= 1'b1;
                pulse_idx <= '0;
              end
            end
          end
          HIGH: begin
            if (cnt == '0) begin
              pulse <= 1'b0;
              if (pulse_idx == len_q) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= LOW;
                cnt   <= gap_cnt;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          LOW: begin
            if (cnt == '0) begin
              state     <= HIGH;
              pulse     <= 1'b1;
              pulse_idx <= pulse_idx + 1'b1;
              cnt       <= {1'b0, width_q};
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Bench for pulse_burst_scheduler: a per-burst queue model of expected outputs, checked every cycle.
module tb_pulse_burst_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       abort;
  logic [3:0] burst_len;
  logic [3:0] pulse_width;
  logic [3:0] gap_min;
  logic [3:0] gap_mask;
  logic       pulse;
  logic       busy;
  logic       done;
  logic [3:0] pulse_idx;
  logic [7:0] lfsr_q;
`ifdef PBS_SEED_LOAD_EN
  logic [7:0] seed;
  logic       seed_load;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  typedef struct packed {
    logic       pulse;
    logic       busy;
    logic       done;
    logic [3:0] idx;
    logic [7:0] lfsr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  pulse_burst_scheduler #(
    .CNT_W  (4),
    .LFSR_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start       (start),
    .abort       (abort),
    .burst_len   (burst_len),
    .pulse_width (pulse_width),
    .gap_min     (gap_min),
    .gap_mask    (gap_mask),
    .pulse       (pulse),
    .busy        (busy),
    .done        (done),
    .pulse_idx   (pulse_idx),
    .lfsr_q      (lfsr_q)
`ifdef PBS_SEED_LOAD_EN
    ,
    .seed        (seed),
    .seed_load   (seed_load)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic [7:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 8'hB8;
    return r;
  endfunction

  function automatic exp_t mk(input logic p, input logic b, input logic d,
                              input logic [3:0] i, input logic [7:0] l);
    exp_t e;
    e.pulse = p;
    e.busy  = b;
    e.done  = d;
    e.idx   = i;
    e.lfsr  = l;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Reference model: a whole burst is expanded into its cycle-by-cycle outputs when start is accepted.
  always @(posedge clk) begin
    logic [7:0] lf;
    int         gap;
    if (!rst_n) begin
      cur = mk(1'b0, 1'b0, 1'b0, 4'd0, 8'hA5);
      exp_q.delete();
    end else if (ena) begin
      if (abort) begin
        cur = mk(1'b0, 1'b0, 1'b0, 4'd0, cur.lfsr);
        exp_q.delete();
      end else if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
      end else if (cur.done) begin
        cur.done = 1'b0;
      end else if (start) begin
        lf = cur.lfsr;
        if (burst_len == 4'd0) begin
          exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'd0, lf));
        end else begin
          for (int p = 1; p <= int'(burst_len); p++) begin
            for (int h = 0; h <= int'(pulse_width); h++)
              exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 4'(p), lf));
            if (p < int'(burst_len)) begin
              gap = int'(gap_min) + 1 + int'(lf[3:0] & gap_mask);
              lf  = lfsr_next(lf);
              for (int g = 0; g < gap; g++)
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'(p), lf));
            end else begin
              exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'(p), lf));
            end
          end
        end
        cur = exp_q.pop_front();
      end
`ifdef PBS_SEED_LOAD_EN
      if (seed_load) cur.lfsr = (seed == 8'h00) ? 8'h01 : seed;
`endif
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_output("pulse", {7'd0, pulse}, {7'd0, cur.pulse});
      check_output("busy", {7'd0, busy}, {7'd0, cur.busy});
      check_output("done", {7'd0, done}, {7'd0, cur.done});
      check_output("pulse_idx", {4'd0, pulse_idx}, {4'd0, cur.idx});
      check_output("lfsr_q", lfsr_q, cur.lfsr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] len, input logic [3:0] pw,
                                input logic [3:0] gm, input logic [3:0] mk_v);
    burst_len   = len;
    pulse_width = pw;
    gap_min     = gm;
    gap_mask    = mk_v;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (exp_q.size() == 0 && !cur.done && !cur.busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL %s: scheduler still busy after 1500 cycles, expected idle", name);
    end
  endtask

  initial begin
    logic [12:0] pv;
    logic [12:0] dv;
    int          lowcnt;
    bit          found;

    rst_n = 1'b0;
    ena = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    burst_len = '0;
    pulse_width = '0;
    gap_min = '0;
    gap_mask = '0;
`ifdef PBS_SEED_LOAD_EN
    seed = '0;
    seed_load = 1'b0;
`endif
    tick();
    check_en = 1'b1;
    tick();
    check_output("reset_pulse", {7'd0, pulse}, 8'd0);
    check_output("reset_busy", {7'd0, busy}, 8'd0);
    check_output("reset_idx", {4'd0, pulse_idx}, 8'd0);
    check_output("reset_lfsr", lfsr_q, 8'hA5);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    // Three 2-cycle pulses separated by 3-cycle gaps, then a done strobe.
    apply_stimulus(4'd3, 4'd1, 4'd2, 4'd0);
    for (int k = 0; k < 13; k++) begin
      pv[12-k] = pulse;
      dv[12-k] = done;
      if (k == 2) check_output("first_gap_lfsr", lfsr_q, 8'hEA);
      if (k == 7) check_output("second_gap_lfsr", lfsr_q, 8'h75);
      tick();
    end
    check_output("burst3_pulse_pattern", 8'(pv >> 5), 8'b11000110);
    check_output("burst3_pulse_tail", {3'd0, pv[4:0]}, 8'b00110);
    check_output("burst3_done_pattern", {3'd0, dv[4:0]}, 8'b00001);
    check_output("burst3_final_idx", {4'd0, pulse_idx}, 8'd3);

    // Zero-length burst completes immediately without any pulse.
    apply_stimulus(4'd0, 4'd2, 4'd1, 4'd0);
    check_output("zero_len_done", {7'd0, done}, 8'd1);
    check_output("zero_len_busy", {7'd0, busy}, 8'd0);
    tick();
    check_output("zero_len_done_clear", {7'd0, done}, 8'd0);

    // Abort in the middle of the second pulse.
    apply_stimulus(4'd3, 4'd3, 4'd1, 4'd0);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (pulse_idx == 4'd2 && pulse) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_output("abort_reached_second_pulse", {7'd0, found}, 8'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_pulse", {7'd0, pulse}, 8'd0);
    check_output("abort_busy", {7'd0, busy}, 8'd0);
    check_output("abort_idx", {4'd0, pulse_idx}, 8'd0);
    tick();

    // Freeze for five cycles inside a 3-cycle gap.
    apply_stimulus(4'd2, 4'd0, 4'd2, 4'd0);
    tick();
    lowcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (pulse) break;
      lowcnt++;
      if (lowcnt == 2) ena = 1'b0;
      if (lowcnt == 7) ena = 1'b1;
      tick();
    end
    ena = 1'b1;
    check_output("frozen_gap_length", 8'(lowcnt), 8'd8);
    wait_idle("freeze_drain");

    // Randomised bursts; inputs keep changing after start to exercise latching.
    for (int b = 0; b < 12; b++) begin
      ena = 1'b1;
      abort = 1'b0;
      apply_stimulus((b < 6) ? 4'($urandom_range(5, 8)) : 4'($urandom_range(0, 8)),
                     4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     (b < 6) ? 4'hF : 4'($urandom_range(0, 15)));
      for (int c = 0; c < 1500; c++) begin
        if (exp_q.size() == 0 && !cur.done && !cur.busy) break;
        start       = 1'($urandom_range(0, 1));
        burst_len   = 4'($urandom_range(0, 15));
        pulse_width = 4'($urandom_range(0, 15));
        gap_min     = 4'($urandom_range(0, 15));
        gap_mask    = 4'($urandom_range(0, 15));
        ena         = ($urandom_range(0, 7) != 0);
        abort       = (b >= 8) && ($urandom_range(0, 39) == 0);
        tick();
      end
      start = 1'b0;
      abort = 1'b0;
      ena   = 1'b1;
      tick();
      wait_idle("random_burst_end");
    end

`ifdef PBS_SEED_LOAD_EN
    seed      = 8'h00;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check_output("seed_zero_load", lfsr_q, 8'h01);
    tick();
`endif

    // Synchronous reset in the middle of a pulse.
    apply_stimulus(4'd3, 4'd5, 4'd1, 4'hF);
    tick();
    rst_n = 1'b0;
    tick();
    check_output("midburst_reset_pulse", {7'd0, pulse}, 8'd0);
    check_output("midburst_reset_busy", {7'd0, busy}, 8'd0);
    check_output("midburst_reset_lfsr", lfsr_q, 8'hA5);
    rst_n = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_burst_scheduler.md
PULSE_BURST_SCHEDULER -- requirements
Module: pulse_burst_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of burst, width and gap fields.
REQ-002 SHALL have parameter LFSR_W, default 8, width of the gap-jitter LFSR.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port ena, input, 1, global enable; 0 freezes all state and outputs.
REQ-006 SHALL have port start, input, 1, burst request, sampled in IDLE only.
REQ-007 SHALL have port abort, input, 1, terminate burst, return to IDLE.
REQ-008 SHALL have port burst_len, input, CNT_W, number of pulses per burst.
REQ-009 SHALL have port pulse_width, input, CNT_W, high time minus one, in cycles.
REQ-010 SHALL have port gap_min, input, CNT_W, minimum low time minus one, in cycles.
REQ-011 SHALL have port gap_mask, input, CNT_W, mask applied to LFSR bits for gap jitter.
REQ-012 SHALL have port pulse, output, 1, registered pulse train.
REQ-013 SHALL have port busy, output, 1, high in HIGH and LOW states.
REQ-014 SHALL have port done, output, 1, one-cycle strobe on normal burst completion.
REQ-015 SHALL have port pulse_idx, output, CNT_W, count of pulses started in the current burst.
REQ-016 SHALL have port lfsr_q, output, LFSR_W, current LFSR state.

Function
REQ-017 SHALL implement FSM states IDLE, HIGH, LOW, DONE.
REQ-018 SHALL, with ena=1, in IDLE with start=1, latch burst_len, pulse_width, gap_min and gap_mask; SHALL ignore later changes to these inputs until the next start.
REQ-019 SHALL, on start, go to HIGH if latched burst_len!=0, else to DONE.
REQ-020 SHALL assert pulse in the first cycle after start is sampled.
REQ-021 SHALL hold HIGH for exactly pulse_width+1 cycles; pulse_idx increments on entry to HIGH.
REQ-022 SHALL, at the end of HIGH, go to DONE if pulse_idx==burst_len, else to LOW.
REQ-023 SHALL hold LOW for gap_min+1+(lfsr_q[CNT_W-1:0] & gap_mask) cycles, computed at LOW entry with a CNT_W+1-bit counter, so it never overflows.
REQ-024 SHALL step the LFSR exactly once per LOW entry: Galois, taps 8'hB8 for LFSR_W=8.
REQ-025 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL, on abort=1 with ena=1 in any state, enter IDLE next cycle, with pulse=0, busy=0, no done and pulse_idx=0.
REQ-028 SHALL give abort priority over start when both are asserted in IDLE.
REQ-029 SHALL, with ena=0, hold every register and output, including counters and the LFSR.

Reset
REQ-030 SHALL, on a rising clk edge with rst_n=0, set state=IDLE, pulse=0, busy=0, done=0, pulse_idx=0, counters=0 and lfsr_q=8'hA5, regardless of ena and of the current state, including mid-burst.

Configuration
REQ-031 SHALL, when PBS_SEED_LOAD_EN is defined, add ports seed (input, LFSR_W) and seed_load (input, 1).
REQ-032 SHALL, under PBS_SEED_LOAD_EN with seed_load=1 and ena=1, load lfsr_q=seed, or 8'h01 if seed==0; seed_load SHALL take priority over the LOW-entry step.
REQ-033 SHALL, without PBS_SEED_LOAD_EN, omit those ports; the LFSR SHALL then be seeded only by reset.

Structure
REQ-034 SHALL place the state enum, the LFSR tap constant 8'hB8 and the reset seed 8'hA5 in shared package pbs_pkg.
REQ-035 SHALL implement the LFSR as sub-module pbs_lfsr, with inputs step, load and load_val, and output q.

Verification
REQ-036 SHALL cover: burst_len=3, width=1, gap_min=2, mask=0 -> pulse high 2 cycles and low 3 cycles, three times; done one cycle after the 3rd pulse falls; pulse_idx ends at 3.
REQ-037 SHALL cover: burst_len=0, start -> done next cycle; pulse never high; busy never high.
REQ-038 SHALL cover: abort during 2nd HIGH -> next cycle pulse=0, busy=0, pulse_idx=0; done never asserted.
REQ-039 SHALL cover: ena=0 for 5 cycles mid-LOW (gap_min=2) -> low time 3+5=8 cycles; lfsr_q unchanged while ena=0.
REQ-040 SHALL cover: mask=4'hF over 20 gaps -> each low time lies in [gap_min+1, gap_min+16] and matches a reference LFSR model from 8'hA5.
REQ-041 SHALL cover: under PBS_SEED_LOAD_EN, seed_load with seed=0 -> lfsr_q=8'h01; rst_n=0 mid-HIGH -> next cycle state IDLE, pulse=0, lfsr_q=8'hA5.
